// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one shared memory port.
//
// The arbiter grants one requester at a time. It latches that requester's
// address, write enable and write data for the whole access. It then waits
// for mem_ack or for a timeout.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   if_req / if_addr    : fetch request (held until if_ready) and fetch address
//   if_rdata / if_ready : registered instruction word; one-cycle completion pulse
//   d_req / d_we        : data request (held until d_ready); 1 = store
//   d_addr / d_wdata    : data address and store data
//   d_rdata / d_ready   : registered load data; one-cycle completion pulse
//   mem_req / mem_we    : shared-port request (high while an access is active), write enable
//   mem_addr / mem_wdata: latched address and write data for the active access
//   mem_rdata / mem_ack : memory read data and completion strobe
//   timeout_err         : sticky flag, set when an access is aborted for lack of ack
module mem_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_t        state;
  state_t        state_next;
  state_t        last_grant;
  logic [CW-1:0] wait_cnt;
  logic          grant_fetch;
  logic          grant_data;
  logic          timeout;
  logic          if_ok;
  logic          d_ok;

  // A requester whose ready pulse is on this cycle still holds req high.
  // Masking that req here keeps the same access from being granted twice.
  assign if_ok   = if_req && !if_ready;
  assign d_ok    = d_req  && !d_ready;
  assign mem_req = (state != IDLE);

  // NOTE: every signal written in this block gets a default first.
  // A missing default on any path would infer a latch.
  always_comb begin
    state_next  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (if_ok && d_ok) begin
          // Round-robin on a tie: the side that was not granted last wins.
          if (last_grant == FETCH) grant_data  = 1'b1;
          else                     grant_fetch = 1'b1;
        end else if (d_ok) begin
          grant_data = 1'b1;
        end else if (if_ok) begin
          grant_fetch = 1'b1;
        end
        if (grant_fetch)     state_next = FETCH;
        else if (grant_data) state_next = DATA;
      end
      FETCH, DATA: begin
        // An ack in the final wait cycle takes priority over the timeout.
        if (mem_ack) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= FETCH;
      wait_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grant_fetch) begin
        last_grant <= FETCH;
        wait_cnt   <= '0;
        mem_addr   <= if_addr;
        mem_we     <= 1'b0;
        mem_wdata  <= '0;
      end else if (grant_data) begin
        last_grant <= DATA;
        wait_cnt   <= '0;
        mem_addr   <= d_addr;
        mem_we     <= d_we;
        mem_wdata  <= d_wdata;
      end

      if (state == FETCH) begin
        if (mem_ack) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else if (timeout) begin
          if_ready    <= 1'b1;
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end else if (state == DATA) begin
        if (mem_ack) begin
          // A store completion leaves the load register untouched.
          if (!mem_we) d_rdata <= mem_rdata;
          d_ready <= 1'b1;
        end else if (timeout) begin
          d_ready     <= 1'b1;
          timeout_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// It runs directed scenarios (fetch, store, contention, timeout, reset
// mid-access, ack on the last wait cycle) and then randomized traffic.
// A transaction-level reference model checks the DUT on every cycle.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 16;
  localparam int OWN_NONE = 0;
  localparam int OWN_F    = 1;
  localparam int OWN_D    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // Owner of the memory port, who won last, and how many cycles the current
  // access has been outstanding, counting the current cycle.
  int          m_owner   = OWN_NONE;
  int          m_last    = OWN_F;
  int          m_elapsed = 0;
  logic [31:0] m_addr    = '0;
  logic        m_we      = 1'b0;
  logic [31:0] m_wdata   = '0;
  logic        m_if_rdy  = 1'b0;
  logic        m_d_rdy   = 1'b0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;
  logic        m_err     = 1'b0;

  always @(posedge clk) begin
    int  pick;
    bit  fin_f, fin_d, want_f, want_d;
    fin_f = 1'b0;
    fin_d = 1'b0;
    if (rst) begin
      m_owner = OWN_NONE; m_last = OWN_F; m_elapsed = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0;
      m_if_rdy = 1'b0; m_d_rdy = 1'b0;
      m_if_rdata = '0; m_d_rdata = '0; m_err = 1'b0;
    end else begin
      if (m_owner == OWN_NONE) begin
        want_f = if_req && !m_if_rdy;
        want_d = d_req  && !m_d_rdy;
        pick = OWN_NONE;
        if (want_f && want_d) pick = (m_last == OWN_D) ? OWN_F : OWN_D;
        else if (want_d)      pick = OWN_D;
        else if (want_f)      pick = OWN_F;
        if (pick != OWN_NONE) begin
          m_owner   = pick;
          m_last    = pick;
          m_elapsed = 1;
          m_addr    = (pick == OWN_F) ? if_addr : d_addr;
          m_we      = (pick == OWN_D) ? d_we : 1'b0;
          m_wdata   = d_wdata;
        end
      end else begin
        if (mem_ack || m_elapsed == MAX_WAIT) begin
          if (mem_ack && m_owner == OWN_F) m_if_rdata = mem_rdata;
          if (mem_ack && m_owner == OWN_D && !m_we) m_d_rdata = mem_rdata;
          if (!mem_ack) m_err = 1'b1;
          fin_f = (m_owner == OWN_F);
          fin_d = (m_owner == OWN_D);
          m_owner = OWN_NONE;
        end else begin
          m_elapsed++;
        end
      end
      m_if_rdy = fin_f;
      m_d_rdy  = fin_d;
    end
  end

  // The compare process checks the DUT against the model every cycle,
  // away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req",     mem_req,     m_owner != OWN_NONE);
      check("if_ready",    if_ready,    m_if_rdy);
      check("d_ready",     d_ready,     m_d_rdy);
      check("if_rdata",    if_rdata,    m_if_rdata);
      check("d_rdata",     d_rdata,     m_d_rdata);
      check("timeout_err", timeout_err, m_err);
      if (m_owner != OWN_NONE) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we",   mem_we,   m_we);
        if (m_owner == OWN_D) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          n;
    int          grants[$];
    logic        prev_req;
    logic [31:0] saved;
    int          ack_div;

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_mem_req",   mem_req, 32'd0);
    check("rst_mem_we",    mem_we, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata",  if_rdata, 32'd0);
    check("rst_d_rdata",   d_rdata, 32'd0);
    check("rst_err",       timeout_err, 32'd0);

    // Fetch with the minimum turnaround: request, ack, ready.
    if_req = 1'b1; if_addr = 32'h10;                  // cycle 0
    @(negedge clk);                                   // cycle 1
    check("fetch_mem_req",  mem_req, 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h10);
    check("fetch_mem_we",   mem_we, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);                                   // cycle 2
    check("fetch_if_ready", if_ready, 32'd1);
    check("fetch_if_rdata", if_rdata, 32'h0050_0093);
    check("fetch_idle",     mem_req, 32'd0);
    if_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("fetch_pulse_end", if_ready, 32'd0);

    // Store acknowledged on its third memory cycle.
    saved = d_rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("store_mem_we",    mem_we, 32'd1);
      check("store_mem_addr",  mem_addr, 32'h100);
      check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
    end
    @(negedge clk);
    check("store_d_ready", d_ready, 32'd1);
    check("store_d_rdata", d_rdata, saved);
    d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("store_pulse_end", d_ready, 32'd0);

    // Contention: both sides held high, memory acks immediately.
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    d_req  = 1'b1; d_addr  = 32'h300; d_we = 1'b0;
    prev_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) grants.push_back((mem_addr == 32'h300) ? OWN_D : OWN_F);
      prev_req  = mem_req;
      mem_ack   = mem_req;
      mem_rdata = 32'hA000_0000 + i;
    end
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    check("rr_grant_count", grants.size(), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check("rr_grant_order", grants[i], (i % 2 == 0) ? OWN_D : OWN_F);
      else                   check("rr_grant_missing", 32'd0, 32'd1);
    end
    @(negedge clk);

    // Timeout: load with no ack.
    do_reset();
    saved = d_rdata;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len",     n, MAX_WAIT);
    check("timeout_d_ready", d_ready, 32'd1);
    check("timeout_flag",    timeout_err, 32'd1);
    check("timeout_rdata",   d_rdata, saved);
    d_req = 1'b0;
    repeat (5) @(negedge clk);
    check("timeout_sticky", timeout_err, 32'd1);
    do_reset();
    check("timeout_cleared", timeout_err, 32'd0);

    // Reset in the middle of a fetch, then a stray ack afterwards.
    if_req = 1'b1; if_addr = 32'h80;                  // cycle 0
    @(negedge clk);                                   // cycle 1
    check("rstmid_mem_req", mem_req, 32'd1);
    @(negedge clk);                                   // cycle 2
    rst = 1'b1;
    @(negedge clk);                                   // cycle 3
    rst = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    check("rstmid_req_low",   mem_req, 32'd0);
    check("rstmid_no_ready3", if_ready, 32'd0);
    @(negedge clk);                                   // cycle 4
    mem_ack = 1'b0;
    check("rstmid_no_ready4", if_ready, 32'd0);
    check("rstmid_rdata",     if_rdata, 32'd0);

    // Ack arriving on the final wait cycle wins over the timeout.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    @(negedge clk);                                   // wait count 0
    repeat (MAX_WAIT - 1) @(negedge clk);             // wait count 15
    check("lastack_still_req", mem_req, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0; d_req = 1'b0;
    check("lastack_ready", d_ready, 32'd1);
    check("lastack_rdata", d_rdata, 32'hCAFE_F00D);
    check("lastack_noerr", timeout_err, 32'd0);
    @(negedge clk);

    // Randomized traffic: a phase with frequent acks, then a slow-memory phase.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ack_div = (c < 3000) ? 3 : 20;
      @(negedge clk);
      if (!if_req || if_ready) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!d_req || d_ready) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (mem_req) mem_ack = ($urandom_range(0, ack_div - 1) == 0);
      else         mem_ack = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
    end
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
